servo_pwm_generator: RTL

//   Servo pulse generator; consumes the divided-clock tick from the clock divider stage as its time base.

---
 rtl/servo_pwm_generator_if.sv | 10 +
 rtl/servo_pwm_generator.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_generator_if.sv
// Position handshake bundle for servo_pwm_generator: the producer drives valid/data,
// the generator returns ready.
interface servo_pwm_generator_if;
  logic        pos_valid;
  logic [15:0] pos_data;
  logic        pos_ready;

  modport master (output pos_valid, output pos_data, input pos_ready);
  modport slave  (input pos_valid, input pos_data, output pos_ready);
endinterface

// File: rtl/servo_pwm_generator.sv
// Servo PWM frame generator: one-entry position buffer, new widths applied only at frame starts.
// Optional macro SERVO_RAMP_EN: active_width slews toward a target by at most RAMP_STEP per frame.
module servo_pwm_generator #(
  parameter logic [15:0] PERIOD_TICKS = 16'd20000,
  parameter logic [15:0] MIN_PULSE    = 16'd1000,
  parameter logic [15:0] MAX_PULSE    = 16'd2000
`ifdef SERVO_RAMP_EN
  , parameter logic [15:0] RAMP_STEP  = 16'd10
`endif
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        enable,
  servo_pwm_generator_if.slave        pos_if,
  output logic                        servo_out,
  output logic                        period_start,
  output logic [15:0]                 active_width
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc_s;
  logic        servo_q, servo_d;
  logic        start_q, start_d;
  logic [15:0] width_q, width_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic        ready_q, ready_d;
  logic        frame_start_s;
  logic        xfer_s;
`ifdef SERVO_RAMP_EN
  logic [15:0] target_q, target_d, target_eff_s;
`endif

  function automatic logic [15:0] clamp_width(input logic [15:0] w);
    logic [15:0] r;
    if (w < MIN_PULSE) begin
      r = MIN_PULSE;
    end else if (w > MAX_PULSE) begin
      r = MAX_PULSE;
    end else begin
      r = w;
    end
    return r;
  endfunction

`ifdef SERVO_RAMP_EN
  function automatic logic [15:0] ramp_toward(input logic [15:0] cur, input logic [15:0] tgt);
    logic [15:0] r;
    if (tgt > cur) begin
      r = ((tgt - cur) > RAMP_STEP) ? (cur + RAMP_STEP) : tgt;
    end else begin
      r = ((cur - tgt) > RAMP_STEP) ? (cur - RAMP_STEP) : tgt;
    end
    return r;
  endfunction
`endif

  // Frame sequencing: the counter only moves on ticks, and a new frame starts from IDLE or at the wrap.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_start_s = 1'b0;
    cnt_inc_s     = cnt_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (tick && enable) begin
          state_d       = ST_HIGH;
          frame_start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          cnt_d   = cnt_inc_s;
          state_d = (cnt_inc_s == width_q) ? ST_LOW : ST_HIGH;
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (tick && (cnt_q == (PERIOD_TICKS - 16'd1))) begin
          cnt_d = 16'd0;
          if (enable) begin
            state_d       = ST_HIGH;
            frame_start_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Pending buffer and width update; ready is not set while the buffer holds a word.
  always_comb begin
    xfer_s       = pos_if.pos_valid && ready_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    if (frame_start_s && pend_valid_q) begin
      pend_valid_d = 1'b0;
    end else if (xfer_s) begin
      pend_valid_d = 1'b1;
      pend_data_d  = clamp_width(pos_if.pos_data);
    end else begin
      pend_valid_d = pend_valid_q;
    end
`ifdef SERVO_RAMP_EN
    target_eff_s = pend_valid_q ? pend_data_q : target_q;
    if (frame_start_s) begin
      target_d = target_eff_s;
      width_d  = ramp_toward(width_q, target_eff_s);
    end else begin
      target_d = target_q;
      width_d  = width_q;
    end
`else
    if (frame_start_s && pend_valid_q) begin
      width_d = pend_data_q;
    end else begin
      width_d = width_q;
    end
`endif
    ready_d = !pend_valid_d;
    servo_d = (state_d == ST_HIGH);
    start_d = frame_start_s;
  end

  // State and output registers; reset drops the pin and any buffered width at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      servo_q      <= 1'b0;
      start_q      <= 1'b0;
      width_q      <= MIN_PULSE;
      pend_valid_q <= 1'b0;
      pend_data_q  <= MIN_PULSE;
      ready_q      <= 1'b1;
`ifdef SERVO_RAMP_EN
      target_q     <= MIN_PULSE;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      servo_q      <= servo_d;
      start_q      <= start_d;
      width_q      <= width_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      ready_q      <= ready_d;
`ifdef SERVO_RAMP_EN
      target_q     <= target_d;
`endif
    end
  end

  assign servo_out        = servo_q;
  assign period_start     = start_q;
  assign active_width     = width_q;
  assign pos_if.pos_ready = ready_q;

endmodule
